// File: rtl/traffic_sensor_conditioner.sv
// Front-end conditioner for the traffic light controller: synchronizes and debounces the
// raw car sensors and mode buttons, strobes button presses and counts rejected glitches.
module traffic_sensor_conditioner #(
    parameter int DB_CNT = 4,
    parameter int CNT_W  = 3
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       ta_raw,
    input  logic       tb_raw,
    input  logic       p_raw,
    input  logic       r_raw,
    output logic       ta,
    output logic       tb,
    output logic       p_pulse,
    output logic       r_pulse,
    output logic [7:0] glitch_cnt
);

    typedef enum logic {
        STABLE = 1'b0,
        PEND   = 1'b1
    } chState_t;

    localparam int                NCH  = 4;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CNT - 1);

    // Channel order in every vector: 0 = ta, 1 = tb, 2 = p, 3 = r.
    logic [NCH-1:0]   r_s1;
    logic [NCH-1:0]   r_s2;
    logic [NCH-1:0]   r_q;
    logic [NCH-1:0]   r_qDly;
    logic [NCH-1:0]   w_qNext;
    logic [NCH-1:0]   w_reject;
    logic [NCH-1:0]   w_rise;
    chState_t         r_state     [NCH];
    chState_t         w_stateNext [NCH];
    logic [CNT_W-1:0] r_cnt       [NCH];
    logic [CNT_W-1:0] w_cntNext   [NCH];
    logic             r_pPulse;
    logic             r_rPulse;
    logic [7:0]       r_glitchCnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= {r_raw, p_raw, tb_raw, ta_raw};
            r_s2 <= r_s1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) r_state[i] <= STABLE;
        end else begin
            for (int i = 0; i < NCH; i++) r_state[i] <= w_stateNext[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_stateNext[i] = r_state[i];
            case (r_state[i])
                STABLE: if (r_s2[i] != r_q[i]) w_stateNext[i] = PEND;
                PEND:   if (r_s2[i] == r_q[i] || r_cnt[i] == LAST) w_stateNext[i] = STABLE;
                default: w_stateNext[i] = STABLE;
            endcase
        end
    end

    // A PEND cycle that sees the old level again is a rejected glitch.
    always_comb begin
        w_qNext  = r_q;
        w_reject = '0;
        for (int i = 0; i < NCH; i++) begin
            w_cntNext[i] = '0;
            case (r_state[i])
                STABLE: if (r_s2[i] != r_q[i]) w_cntNext[i] = CNT_W'(1);
                PEND: begin
                    if (r_s2[i] == r_q[i])   w_reject[i] = 1'b1;
                    else if (r_cnt[i] == LAST) w_qNext[i] = ~r_q[i];
                    else                       w_cntNext[i] = r_cnt[i] + CNT_W'(1);
                end
                default: w_cntNext[i] = '0;
            endcase
        end
    end

    assign w_rise = r_q & ~r_qDly;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) r_cnt[i] <= '0;
            r_q         <= '0;
            r_qDly      <= '0;
            r_pPulse    <= 1'b0;
            r_rPulse    <= 1'b0;
            r_glitchCnt <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) r_cnt[i] <= w_cntNext[i];
            r_q      <= w_qNext;
            r_qDly   <= r_q;
            // Release outranks parade; a coincident parade edge is dropped.
            r_pPulse <= w_rise[2] & ~w_rise[3];
            r_rPulse <= w_rise[3];
            if (|w_reject && r_glitchCnt != 8'hFF) r_glitchCnt <= r_glitchCnt + 8'd1;
        end
    end

    assign ta         = r_q[0];
    assign tb         = r_q[1];
    assign p_pulse    = r_pPulse;
    assign r_pulse    = r_rPulse;
    assign glitch_cnt = r_glitchCnt;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Self-checking bench for traffic_sensor_conditioner: directed scenarios plus random sensor
// activity, compared each cycle against a run-length model of the debounce rules.
module tb_traffic_sensor_conditioner;

    localparam int DB = 4;

    logic       clk;
    logic       rstn;
    logic       ta_raw, tb_raw, p_raw, r_raw;
    logic       ta, tb, p_pulse, r_pulse;
    logic [7:0] glitch_cnt;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference model: synchronizer stages, debounced level, length of the current run of
    // samples disagreeing with that level, and the level seen one edge earlier.
    int mS1[4], mS2[4], mQ[4], mRun[4], mQPrev[4];
    int mG;
    int expP, expR;
    int pCount, rCount;

    traffic_sensor_conditioner #(.DB_CNT(DB), .CNT_W(3)) dut (
        .clk(clk), .rstn(rstn),
        .ta_raw(ta_raw), .tb_raw(tb_raw), .p_raw(p_raw), .r_raw(r_raw),
        .ta(ta), .tb(tb), .p_pulse(p_pulse), .r_pulse(r_pulse),
        .glitch_cnt(glitch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelReset();
        for (int c = 0; c < 4; c++) begin
            mS1[c] = 0; mS2[c] = 0; mQ[c] = 0; mRun[c] = 0; mQPrev[c] = 0;
        end
        mG = 0; expP = 0; expR = 0;
    endtask

    task automatic modelEdge(input logic [3:0] raw);
        int  oldQ[4];
        bit  anyRej;
        bit  riseP, riseR;
        anyRej = 0;
        for (int c = 0; c < 4; c++) oldQ[c] = mQ[c];
        for (int c = 0; c < 4; c++) begin
            if (mS2[c] != mQ[c]) begin
                mRun[c]++;
                if (mRun[c] == DB) begin
                    mQ[c]   = 1 - mQ[c];
                    mRun[c] = 0;
                end
            end else begin
                if (mRun[c] > 0) anyRej = 1;
                mRun[c] = 0;
            end
        end
        riseP = (mQPrev[2] == 0) && (oldQ[2] == 1);
        riseR = (mQPrev[3] == 0) && (oldQ[3] == 1);
        expR  = riseR ? 1 : 0;
        expP  = (riseP && !riseR) ? 1 : 0;
        for (int c = 0; c < 4; c++) mQPrev[c] = oldQ[c];
        if (anyRej && mG < 255) mG++;
        for (int c = 0; c < 4; c++) begin
            mS2[c] = mS1[c];
            mS1[c] = int'(raw[c]);
        end
    endtask

    task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkVal("ta", {7'd0, ta}, 8'(mQ[0]));
        checkVal("tb", {7'd0, tb}, 8'(mQ[1]));
        checkVal("p_pulse", {7'd0, p_pulse}, 8'(expP));
        checkVal("r_pulse", {7'd0, r_pulse}, 8'(expR));
        checkVal("glitch_cnt", glitch_cnt, 8'(mG));
    endtask

    task automatic applyStimulus(input logic a, input logic b, input logic p, input logic r);
        ta_raw = a; tb_raw = b; p_raw = p; r_raw = r;
    endtask

    task automatic tick();
        logic [3:0] raw;
        @(posedge clk);
        raw = {r_raw, p_raw, tb_raw, ta_raw};
        if (rstn) modelEdge(raw);
        #1;
        checkOutput();
        pCount += int'(p_pulse);
        rCount += int'(r_pulse);
    endtask

    task automatic assertReset();
        rstn = 1'b0;
        modelReset();
        #1;
        checkOutput();
    endtask

    initial begin
        rstn = 1'b1;
        applyStimulus(0, 0, 0, 0);
        pCount = 0; rCount = 0;
        modelReset();
        #2;

        // Reset state, then ta rises on the sixth edge after release.
        assertReset();
        tick(); tick();
        #2 rstn = 1'b1;
        applyStimulus(1, 0, 0, 0);
        for (int i = 1; i <= 5; i++) tick();
        checkVal("ta_before_edge6", {7'd0, ta}, 8'd0);
        tick();
        checkVal("ta_at_edge6", {7'd0, ta}, 8'd1);
        checkVal("pulses_during_ta", 8'(pCount + rCount), 8'd0);

        // Two-cycle tb blip is rejected and counted once.
        applyStimulus(1, 1, 0, 0);
        tick(); tick();
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick();
        checkVal("tb_glitch_level", {7'd0, tb}, 8'd0);
        checkVal("tb_glitch_count", glitch_cnt, 8'd1);

        // Held parade button: one pulse; release gives none and no glitch.
        pCount = 0; rCount = 0;
        applyStimulus(1, 0, 1, 0);
        for (int i = 0; i < 20; i++) tick();
        checkVal("p_hold_pulses", 8'(pCount), 8'd1);
        pCount = 0;
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick();
        checkVal("p_release_pulses", 8'(pCount), 8'd0);
        checkVal("p_release_glitch", glitch_cnt, 8'd1);

        // Coincident parade and release presses: release wins.
        pCount = 0; rCount = 0;
        applyStimulus(1, 0, 1, 1);
        for (int i = 0; i < 12; i++) tick();
        checkVal("pr_r_pulses", 8'(rCount), 8'd1);
        checkVal("pr_p_pulses", 8'(pCount), 8'd0);
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick();

        // Random sensor and button activity.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0) ? ~ta_raw : ta_raw,
                          ($urandom_range(0, 3) == 0) ? ~tb_raw : tb_raw,
                          ($urandom_range(0, 4) == 0) ? ~p_raw  : p_raw,
                          ($urandom_range(0, 4) == 0) ? ~r_raw  : r_raw);
            tick();
        end

        // Settle low, then a chattering ta sensor saturates the glitch counter.
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 12; i++) tick();
        for (int i = 0; i < 600; i++) begin
            applyStimulus(logic'(i % 2), 0, 0, 0);
            tick();
        end
        checkVal("toggle_ta_level", {7'd0, ta}, 8'd0);
        checkVal("toggle_saturated", glitch_cnt, 8'd255);
        applyStimulus(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick();

        // Reset clears a settled high level at once and holds it down.
        applyStimulus(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick();
        checkVal("ta_high_before_reset", {7'd0, ta}, 8'd1);
        #2 assertReset();
        checkVal("ta_cleared_by_reset", {7'd0, ta}, 8'd0);
        checkVal("glitch_cleared_by_reset", glitch_cnt, 8'd0);
        for (int i = 0; i < 3; i++) tick();
        #2 rstn = 1'b1;
        for (int i = 0; i < 3; i++) tick();

        // Reset during a pending count restarts the debounce from scratch.
        #2 assertReset();
        tick();
        #2 rstn = 1'b1;
        pCount = 0; rCount = 0;
        for (int i = 1; i <= 5; i++) tick();
        checkVal("ta_restart_before_edge6", {7'd0, ta}, 8'd0);
        tick();
        checkVal("ta_restart_at_edge6", {7'd0, ta}, 8'd1);
        checkVal("no_pulse_after_reset", 8'(pCount + rCount), 8'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
